// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST session controller.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        CAPTURE,
        DONE
    } bist_ctrl_state_e;

    localparam int BIST_CLEAR_CYCLES = 2;
    localparam int BIST_FAILCNT_W    = 8;

endpackage

// File: rtl/bist_cycle_counter.sv
// Load/enable cycle counter with terminal-count flag; holds at the terminal value.
module bist_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= '0;
        else if (en && !tc)
            count <= count + 1'b1;
    end

    assign tc = (count == term);

endmodule

// File: rtl/bist_ctrl.sv
// BIST session controller: clear, run PAT_COUNT patterns, capture and grade the MISR signature.
// Optional macro BIST_CTRL_FAILCNT_EN adds a saturating fail_count output.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PAT_COUNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic [WIDTH-1:0] misr_signature,
    input  logic             scan_req,
    output logic             bist_rstn,
    output logic             bist_mode,
    output logic             scan_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail
`ifdef BIST_CTRL_FAILCNT_EN
    ,
    output logic [BIST_FAILCNT_W-1:0] fail_count
`endif
);

    localparam int CNT_W = $clog2(PAT_COUNT + 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(PAT_COUNT - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(BIST_CLEAR_CYCLES - 1);

    bist_ctrl_state_e state_q, state_d;
    logic             cnt_load, cnt_en, cnt_tc;
    logic [CNT_W-1:0] cnt_term;
    logic             rstn_d, mode_d, busy_d, done_d;
    logic             sig_match;

    bist_cycle_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .term (cnt_term),
        .tc   (cnt_tc)
    );

    // One counter serves both timed phases; it restarts on every state change.
    assign cnt_load  = (state_d != state_q);
    assign cnt_en    = (state_q == CLEAR) || (state_q == RUN);
    assign cnt_term  = (state_q == RUN) ? RUN_LAST : CLEAR_LAST;
    assign sig_match = (misr_signature == golden_sig);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // DONE hands a held start straight to CLEAR so back-to-back sessions have no idle gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   if (cnt_tc) state_d = RUN;
            RUN:     if (cnt_tc) state_d = CAPTURE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = start ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rstn_d = (state_d != CLEAR);
        mode_d = (state_d == RUN);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bist_rstn <= 1'b0;
            bist_mode <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            bist_rstn <= rstn_d;
            bist_mode <= mode_d;
            busy      <= busy_d;
            done      <= done_d;
            if (state_q != CLEAR && state_d == CLEAR) begin
                pass <= 1'b0;
                fail <= 1'b0;
            end else if (state_q == CAPTURE) begin
                pass <= sig_match;
                fail <= !sig_match;
            end
        end
    end

    // busy is low in IDLE, so scan is only granted outside a session.
    assign scan_en = scan_req & ~busy;

`ifdef BIST_CTRL_FAILCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fail_count <= '0;
        else if (state_q == CAPTURE && !sig_match && fail_count != '1)
            fail_count <= fail_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl: offset-based session model plus directed and random stimulus.
module tb_bist_ctrl;

    localparam int P = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] golden_sig = '0;
    logic [W-1:0] misr_signature = '0;
    logic         scan_req = 1'b1;
    logic         bist_rstn, bist_mode, scan_en, busy, done, pass, fail;
`ifdef BIST_CTRL_FAILCNT_EN
    logic [7:0]   fail_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    bist_ctrl #(.WIDTH(W), .PAT_COUNT(P)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .golden_sig     (golden_sig),
        .misr_signature (misr_signature),
        .scan_req       (scan_req),
        .bist_rstn      (bist_rstn),
        .bist_mode      (bist_mode),
        .scan_en        (scan_en),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail           (fail)
`ifdef BIST_CTRL_FAILCNT_EN
        ,
        .fail_count     (fail_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a session is described only by the cycle offset t since its start edge.
    bit m_active = 0;
    bit m_ready  = 0;
    int m_t      = 0;
    bit m_pass   = 0;
    bit m_fail   = 0;
`ifdef BIST_CTRL_FAILCNT_EN
    int m_fcnt   = 0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_ready = 0; m_t = 0; m_pass = 0; m_fail = 0;
`ifdef BIST_CTRL_FAILCNT_EN
            m_fcnt = 0;
`endif
        end else begin
            m_ready = 1;
            if (m_active && m_t == P + 2) begin
                m_pass = (misr_signature == golden_sig);
                m_fail = !m_pass;
`ifdef BIST_CTRL_FAILCNT_EN
                if (m_fail && m_fcnt < 255) m_fcnt++;
`endif
            end
            if (m_active && m_t == P + 3) begin
                if (start) begin m_t = 0; m_pass = 0; m_fail = 0; end
                else m_active = 0;
            end else if (m_active) begin
                m_t++;
            end else if (start) begin
                m_active = 1; m_t = 0; m_pass = 0; m_fail = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy",      busy,      m_active);
            chk("bist_rstn", bist_rstn, m_ready && !(m_active && m_t < 2));
            chk("bist_mode", bist_mode, m_active && m_t >= 2 && m_t <= P + 1);
            chk("done",      done,      m_active && m_t == P + 3);
            chk("pass",      pass,      m_pass);
            chk("fail",      fail,      m_fail);
            chk("scan_en",   scan_en,   scan_req && !m_active);
            chk("mode_scan_excl", bist_mode && scan_en, 0);
`ifdef BIST_CTRL_FAILCNT_EN
            chk("fail_count", fail_count, m_fcnt);
`endif
        end
    end

    task automatic check_reset_outputs();
        chk("rst_bist_rstn", bist_rstn, 0);
        chk("rst_bist_mode", bist_mode, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_done",      done,      0);
        chk("rst_pass",      pass,      0);
        chk("rst_fail",      fail,      0);
        chk("rst_scan_en",   scan_en,   scan_req);
    endtask

    // Called at posedge+2; returns at posedge+2 of the DONE cycle.
    task automatic run_session(input logic [W-1:0] g, input logic [W-1:0] m,
                               output int lat, output int mode_cnt, output int rstn_lo);
        golden_sig = g;
        misr_signature = m;
        start = 1'b1;
        lat = -1; mode_cnt = 0; rstn_lo = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #2;
            if (i == 1) start = 1'b0;
            if (bist_mode) mode_cnt++;
            if (!bist_rstn) rstn_lo++;
            if (done) begin lat = i - 1; break; end
        end
    endtask

    int lat, mcnt, rlo, dcnt, d1, d2;

    initial begin
        #1;
        check_reset_outputs();
        #11 rst = 1'b0;
        @(posedge clk); #2;
        chk("idle_rstn", bist_rstn, 1);
        chk("idle_scan_en", scan_en, 1);

        // Pass session
        run_session(4'b1010, 4'b1010, lat, mcnt, rlo);
        chk("pass_latency", lat, 19);
        chk("pass_mode_cycles", mcnt, 16);
        chk("pass_rstn_low", rlo, 2);
        chk("pass_flag", pass, 1);
        chk("pass_fail_flag", fail, 0);
        @(posedge clk); #2;
        chk("pass_hold", pass, 1);
        chk("scan_after_done", scan_en, 1);

        // Fail session
        run_session(4'b1011, 4'b1010, lat, mcnt, rlo);
        chk("fail_latency", lat, 19);
        chk("fail_flag", fail, 1);
        chk("fail_pass_flag", pass, 0);
`ifdef BIST_CTRL_FAILCNT_EN
        chk("fail_count_one", fail_count, 1);
        for (int s = 0; s < 255; s++) run_session(4'b1011, 4'b1010, lat, mcnt, rlo);
        chk("fail_count_sat", fail_count, 255);
`endif
        @(posedge clk); #2;

        // start pulsed during RUN is ignored
        start = 1'b1;
        dcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #2;
            start = (i == 5);
            if (i == 5) chk("in_run_for_pulse", bist_mode, 1);
            if (done) dcnt++;
        end
        chk("single_done", dcnt, 1);

        // start held high: back-to-back sessions
        start = 1'b1;
        d1 = -1; d2 = -1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #2;
            if (d1 >= 0 && i == d1 + 1) chk("b2b_clear_rstn", bist_rstn, 0);
            if (done) begin
                if (d1 < 0) d1 = i;
                else begin d2 = i; start = 1'b0; break; end
            end
        end
        chk("b2b_period", d2 - d1, P + 4);
        repeat (3) @(posedge clk);
        #2;

        // Reset in the 8th pattern cycle
        start = 1'b1;
        mcnt = 0;
        for (int i = 1; i <= 40 && mcnt < 8; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (bist_mode) mcnt++;
        end
        chk("reached_8th_pattern", mcnt, 8);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk); #2 rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #2;
            if (done) dcnt++;
        end
        chk("no_done_after_reset", dcnt, 0);
        run_session(4'b0110, 4'b0110, lat, mcnt, rlo);
        chk("post_reset_latency", lat, 19);
        chk("post_reset_pass", pass, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) == 0);
            scan_req = $urandom_range(0, 1);
            golden_sig = W'($urandom);
            misr_signature = $urandom_range(0, 1) ? golden_sig : W'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                #1;
                check_reset_outputs();
                @(posedge clk); #2 rst = 1'b0;
            end
        end

        @(posedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

Session controller that drives the `bist_top` datapath from the initiator side. On a `start` request it:
- clears the LFSR/MISR datapath;
- runs a fixed number of pattern cycles in BIST mode;
- freezes and samples the MISR signature;
- compares the signature against a golden value and reports pass/fail with a done pulse.

It sits between system test logic (or a JTAG user register) and `bist_top`, and owns `bist_mode`, `scan_en` and the datapath reset.

## Interface
Parameters:
- `WIDTH`, 4, MISR signature width; must match `bist_top`.
- `PAT_COUNT`, 16, number of BIST pattern cycles per session; legal range 1..65535.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  session request; sampled only in IDLE.
- `golden_sig`  input  WIDTH  expected signature; sampled in CAPTURE.
- `misr_signature`  input  WIDTH  signature from `bist_top`.
- `scan_req`  input  1  scan-mode request from test logic.
- `bist_rstn`  output  1  active-low reset to `bist_top`.
- `bist_mode`  output  1  BIST enable to `bist_top`.
- `scan_en`  output  1  scan enable to `bist_top`.
- `busy`  output  1  high from CLEAR through DONE.
- `done`  output  1  one-cycle pulse at session end.
- `pass`  output  1  last session matched.
- `fail`  output  1  last session mismatched.

## Operation
States and transitions:
- IDLE: moves to CLEAR when `start`=1.
- CLEAR: lasts 2 cycles, with `bist_rstn`=0; then moves to RUN.
- RUN: lasts exactly `PAT_COUNT` cycles, with `bist_mode`=1; then moves to CAPTURE.
- CAPTURE: lasts 1 cycle, with `bist_mode`=0 (MISR frozen). The edge leaving CAPTURE registers `misr_signature == golden_sig` into `pass`/`fail`.
- DONE: lasts 1 cycle, with `done`=1; then moves to IDLE.

Output behaviour:
- `bist_rstn`: 1 in IDLE, RUN, CAPTURE and DONE.
- `pass`/`fail`: mutually exclusive; both clear on the edge entering CLEAR; hold from DONE until the next session starts.
- `scan_en` = `scan_req` & ~`busy`. Scan is blocked for the whole session and `bist_mode` and `scan_en` are never both 1.
- The pattern counter is `$clog2(PAT_COUNT+1)` bits wide, loads 0 entering RUN and compares against `PAT_COUNT-1`. There is no wrap-around.

Boundary conditions:
- `start` while busy is ignored and not queued.
- `start` held high produces back-to-back sessions; the next CLEAR begins the cycle after DONE.
- `rst` at any time returns to IDLE immediately. No `done` is produced for the interrupted session.
- `PAT_COUNT`=1 gives a single RUN cycle.

## Timing
- Reset values: `bist_rstn`=0, `bist_mode`=0, `busy`=0, `done`=0, `pass`=0, `fail`=0. `scan_en` follows `scan_req`.
- All outputs except `scan_en` are registered.
- If `start` is sampled at edge N:
  - CLEAR during cycles N..N+1;
  - `bist_mode` high for cycles N+2..N+PAT_COUNT+1;
  - CAPTURE at N+PAT_COUNT+2;
  - `done`, `pass`/`fail` valid after edge N+PAT_COUNT+3.
- Start-to-done latency is `PAT_COUNT`+3 cycles (19 at the default).
- `misr_signature` must be stable in CAPTURE. `bist_top` holds the MISR when `bist_mode`=0.

## Configuration
- `BIST_CTRL_FAILCNT_EN`:
  - Defined: adds output `fail_count` [7:0], reset to 0. It increments on every DONE with `fail`=1, saturates at 255, and clears only on `rst`.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `bist_pkg`:
  - state enum `bist_ctrl_state_e` (IDLE, CLEAR, RUN, CAPTURE, DONE);
  - constants `BIST_CLEAR_CYCLES`=2 and `BIST_FAILCNT_W`=8.
- One sub-module `bist_cycle_counter`: a parameterised load/enable counter with a terminal-count flag, reused for CLEAR and RUN.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs at their reset values asynchronously, before the next edge.
- Pass: model MISR ends at 4'b1010, `golden_sig`=4'b1010, 1-cycle `start` → `bist_rstn` low 2 cycles, `bist_mode` high exactly 16 cycles, `done` 19 cycles after start, `pass`=1, `fail`=0.
- Fail: `golden_sig`=4'b1011, same stimulus → `fail`=1, `pass`=0. With `BIST_CTRL_FAILCNT_EN`, `fail_count`=1; after 256 failing sessions, `fail_count`=255.
- Start handling:
  - `start` pulsed in RUN → ignored; exactly one `done`.
  - `start` held high → second CLEAR begins the cycle after the first `done`.
- Reset mid-RUN (8th pattern cycle) → `bist_mode`=0, `busy`=0 immediately, no `done`. A following `start` completes normally in 19 cycles.
- Scan interlock: `scan_req`=1 throughout → `scan_en`=1 in IDLE, 0 from CLEAR through DONE, 1 again after DONE.
